// File: rtl/port_alloc.sv
// Oldest-first output-port allocator for the 5-port bufferless deflection router.
// Optional injection burst throttle is enabled with `ALLOC_INJ_THROTTLE_EN.
module port_alloc #(
  parameter int WIDTH_AGE = 8
`ifdef ALLOC_INJ_THROTTLE_EN
  , parameter int INJ_BURST = 4
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             in_valid,
  input  logic [19:0]            in_prod,
  input  logic [4*WIDTH_AGE-1:0] in_age,
  input  logic                   inj_valid,
  input  logic [4:0]             inj_prod,
  output logic                   inj_ready,
  output logic [4:0]             out_valid,
  output logic [24:0]            out_grant,
  output logic [5*WIDTH_AGE-1:0] out_age
);

  localparam logic [WIDTH_AGE-1:0] AGE_MAX = '1;

  logic                        inj_acc;
  logic [4:0]                  req;
  logic [4:0][4:0]             prod;
  logic [4:0][WIDTH_AGE-1:0]   age;
  logic [4:0][2:0]             rank;

  logic [4:0]                  free;
  logic [4:0]                  cand;
  logic                        found;
  logic [2:0]                  pick;

  logic [4:0]                  valid_d, valid_q;
  logic [4:0][4:0]             grant_d, grant_q;
  logic [4:0][WIDTH_AGE-1:0]   age_d, age_q;

  // Self-addressed injection is illegal, so the LOCAL bit of inj_prod is never honoured.
  logic unused_inj_local;
  assign unused_inj_local = inj_prod[4];

`ifdef ALLOC_INJ_THROTTLE_EN
  localparam int CW = $clog2(INJ_BURST + 1);

  logic [CW-1:0] burst_d, burst_q;

  assign inj_ready = ~&in_valid & (burst_q < CW'(INJ_BURST));

  always_comb begin
    burst_d = '0;
    if (inj_acc) begin
      burst_d = (burst_q == CW'(INJ_BURST)) ? burst_q : burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign inj_ready = ~&in_valid;
`endif

  assign inj_acc = inj_valid & inj_ready;

  always_comb begin
    req  = '0;
    prod = '0;
    age  = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]  = in_valid[i];
      prod[i] = in_prod[5*i +: 5];
      age[i]  = in_age[WIDTH_AGE*i +: WIDTH_AGE];
    end
    req[4]  = inj_acc;
    prod[4] = {1'b0, inj_prod[3:0]};
    age[4]  = '0;
  end

  // Rank = number of valid requesters that beat this one (older, or equal age and lower index).
  always_comb begin
    rank = '0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 5; j++) begin
        if (j != r && req[j] &&
            ((age[j] > age[r]) || ((age[j] == age[r]) && (j < r)))) begin
          rank[r] = rank[r] + 3'd1;
        end
      end
    end
  end

  // Greedy allocation walking the ranks in priority order; deflection never uses LOCAL.
  always_comb begin
    free    = 5'b11111;
    grant_d = '0;
    age_d   = '0;
    valid_d = req;
    cand    = '0;
    found   = 1'b0;
    pick    = '0;
    for (int p = 0; p < 5; p++) begin
      for (int r = 0; r < 5; r++) begin
        if (req[r] && (rank[r] == 3'(p))) begin
          cand  = prod[r] & free;
          found = |cand;
          if (!found) begin
            cand = free & 5'b01111;
          end
          pick = '0;
          for (int b = 0; b < 5; b++) begin
            if (cand[b]) begin
              pick = 3'(b);
            end
          end
          grant_d[r][pick] = 1'b1;
          free[pick]       = 1'b0;
          if (found || (age[r] == AGE_MAX)) begin
            age_d[r] = age[r];
          end else begin
            age_d[r] = age[r] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      grant_q <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      grant_q <= grant_d;
      age_q   <= age_d;
    end
  end

  assign out_valid = valid_q;
  assign out_grant = grant_q;
  assign out_age   = age_q;

endmodule

// File: tb/tb_port_alloc.sv
// Scoreboard bench for port_alloc: a sort-and-assign reference model feeds an
// expected queue that a free-running monitor drains one cycle after each request.
module tb_port_alloc;

  localparam int WA    = 8;
  localparam int EXP_W = 5 + 25 + 5*WA;
`ifdef ALLOC_INJ_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [19:0]     in_prod;
  logic [4*WA-1:0] in_age;
  logic            inj_valid;
  logic [4:0]      inj_prod;
  logic            inj_ready;
  logic [4:0]      out_valid;
  logic [24:0]     out_grant;
  logic [5*WA-1:0] out_age;

  port_alloc #(.WIDTH_AGE(WA)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_age    (in_age),
    .inj_valid (inj_valid),
    .inj_prod  (inj_prod),
    .inj_ready (inj_ready),
    .out_valid (out_valid),
    .out_grant (out_grant),
    .out_age   (out_age)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               streak = 0;
  logic             last_rdy;

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_ready(input logic [3:0] v, input int s);
    return (~&v) && !(THR && s >= 4);
  endfunction

  function automatic logic [EXP_W-1:0] model_out(input logic [3:0] v, input logic [19:0] pr,
                                                 input logic [4*WA-1:0] ag, input logic acc,
                                                 input logic [4:0] ip);
    int         order[$];
    int         a[5];
    logic [4:0] p[5];
    logic [4:0] vv;
    logic [4:0] free;
    logic [4:0] cand;
    logic [24:0] eg;
    logic [5*WA-1:0] ea;
    int         pos;
    int         port;
    bit         ok;
    for (int i = 0; i < 4; i++) begin
      a[i]  = int'(ag[WA*i +: WA]);
      p[i]  = pr[5*i +: 5];
      vv[i] = v[i];
    end
    a[4]  = 0;
    p[4]  = {1'b0, ip[3:0]};
    vv[4] = acc;
    // Stable insertion by age: only a strictly older flit jumps ahead of an earlier index.
    for (int r = 0; r < 5; r++) begin
      if (vv[r]) begin
        pos = order.size();
        for (int k = order.size() - 1; k >= 0; k--) begin
          if (a[r] > a[order[k]]) pos = k;
        end
        order.insert(pos, r);
      end
    end
    free = 5'h1F;
    eg   = '0;
    ea   = '0;
    foreach (order[k]) begin
      cand = p[order[k]] & free;
      ok   = (cand != 0);
      if (!ok) cand = free & 5'h0F;
      port = -1;
      for (int b = 4; b >= 0; b--) begin
        if (cand[b] && port < 0) port = b;
      end
      if (port >= 0) begin
        eg[5*order[k] + port] = 1'b1;
        free[port] = 1'b0;
        if (ok || a[order[k]] == (1 << WA) - 1) ea[WA*order[k] +: WA] = WA'(a[order[k]]);
        else                                    ea[WA*order[k] +: WA] = WA'(a[order[k]] + 1);
      end
    end
    return {vv, eg, ea};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] v, input logic [19:0] pr, input logic [4*WA-1:0] ag,
                       input logic iv, input logic [4:0] ip);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_prod   = pr;
    in_age    = ag;
    inj_valid = iv;
    inj_prod  = ip;
    #1;
    exp_rdy = model_ready(v, streak);
    check("inj_ready", EXP_W'(inj_ready), EXP_W'(exp_rdy));
    last_rdy = inj_ready;
    acc = iv && exp_rdy;
    exp_q.push_back(model_out(v, pr, ag, acc, ip));
    streak = acc ? ((streak < 4) ? streak + 1 : streak) : 0;
  endtask

  task automatic idle();
    drive(4'h0, 20'h0, '0, 1'b0, 5'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    int cnt;
    int dup;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("alloc_out", {out_valid, out_grant, out_age}, e);
        dup = 0;
        for (int b = 0; b < 5; b++) begin
          cnt = 0;
          for (int r = 0; r < 5; r++) if (out_grant[5*r + b]) cnt++;
          if (cnt > 1) dup++;
        end
        check("grant_exclusive", EXP_W'(dup), '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [WA-1:0] rand_age();
    case ($urandom_range(0, 2))
      0:       return WA'($urandom_range(0, 3));
      1:       return WA'($urandom_range(250, 255));
      default: return WA'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [9:0]      rdy_pat;
    logic [4*WA-1:0] ag;
    logic [19:0]     pr;

    reset     = 1'b1;
    in_valid  = '0;
    in_prod   = '0;
    in_age    = '0;
    inj_valid = 1'b0;
    inj_prod  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_valid, out_grant, out_age}, '0);
    @(negedge clk);
    reset = 1'b0;

    // Ages 5/9/9/2, all productive only on E.
    drive(4'hF, {4{5'b00010}}, {8'd2, 8'd9, 8'd9, 8'd5}, 1'b0, 5'h0);
    // Two LOCAL-bound flits: only the older one ejects.
    drive(4'b0101, {5'b0, 5'b10000, 5'b0, 5'b10000}, {8'd0, 8'd7, 8'd0, 8'd3}, 1'b0, 5'h0);
    // Saturated age, productive on N|E; younger N-only flit deflects.
    drive(4'b0011, {10'b0, 5'b01000, 5'b01010}, {16'd0, 8'd0, 8'd255}, 1'b0, 5'h0);
    // Three W-bound flits of equal age plus an injected W-bound flit.
    drive(4'b0111, {5'b0, 5'b00001, 5'b00001, 5'b00001}, {8'd0, 8'd1, 8'd1, 8'd1}, 1'b1, 5'b00001);
    // Self-addressed injection bit must be ignored.
    drive(4'b0001, {15'b0, 5'b10000}, {24'd0, 8'd4}, 1'b1, 5'b10000);
    idle();

    // Injection held high with no network traffic.
    for (int k = 0; k < 10; k++) begin
      drive(4'h0, 20'h0, '0, 1'b1, 5'b00001);
      rdy_pat[k] = last_rdy;
    end
    check("inj_burst_pattern", EXP_W'(rdy_pat), THR ? EXP_W'(10'b0111101111) : EXP_W'(10'b1111111111));
    idle();

    // Asynchronous reset mid-operation.
    drive(4'hF, {4{5'b00010}}, {8'd2, 8'd9, 8'd9, 8'd5}, 1'b0, 5'h0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {out_valid, out_grant, out_age}, '0);
    exp_q.delete();
    streak    = 0;
    in_valid  = '0;
    inj_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1001, {5'b00100, 10'b0, 5'b00100}, {8'd6, 16'd0, 8'd6}, 1'b1, 5'b00100);
    idle();

    // Randomized traffic with tie-heavy and near-saturation ages.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        ag[WA*i +: WA] = rand_age();
        pr[5*i +: 5]   = 5'($urandom_range(0, 31));
      end
      drive(4'($urandom_range(0, 15)), pr, ag, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    check("scoreboard_drain", EXP_W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
